// File: rtl/median_filter_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | median_filter_stream                                                     |
// | Streaming 3x3 rank filter (bypass/median/min/max) with two line buffers,  |
// | a 3-stage sorting network, valid/ready backpressure and border copy.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module median_filter_stream #(
    parameter int PIX_W     = 8,
    parameter int MAX_WIDTH = 1024,
    parameter int DIM_W     = 11
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start_i,
    input  logic [DIM_W-1:0] img_width_i,
    input  logic [DIM_W-1:0] img_height_i,
    input  logic [1:0]       mode_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [PIX_W-1:0] s_pixel_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [PIX_W-1:0] m_pixel_o,
    output logic             m_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int             C_ADDR_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [DIM_W:0] C_MAX_W  = (DIM_W+1)'(MAX_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [PIX_W-1:0] f_min2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [PIX_W-1:0] f_max2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [PIX_W-1:0] f_min3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                                input logic [PIX_W-1:0] c);
        return f_min2(f_min2(a, b), c);
    endfunction

    function automatic logic [PIX_W-1:0] f_max3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                                input logic [PIX_W-1:0] c);
        return f_max2(f_max2(a, b), c);
    endfunction

    function automatic logic [PIX_W-1:0] f_med3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                                input logic [PIX_W-1:0] c);
        return f_max2(f_min2(a, b), f_min2(f_max2(a, b), c));
    endfunction

    state_t           r_state;
    logic [1:0]       r_mode;
    logic [DIM_W-1:0] r_w_m1;
    logic [DIM_W-1:0] r_h_m1;
    logic [DIM_W-1:0] r_in_col;
    logic [DIM_W:0]   r_in_row;
    logic [DIM_W-1:0] r_c_col;
    logic [DIM_W-1:0] r_c_row;
    logic             r_emit_done;
    logic             r_err;

    logic [PIX_W-1:0] r_lb_top [MAX_WIDTH];
    logic [PIX_W-1:0] r_lb_mid [MAX_WIDTH];

    logic [PIX_W-1:0] r_win [3][3];
    logic             r_win_valid;
    logic             r_win_border;
    logic             r_win_last;

    logic [PIX_W-1:0] r_s1_lo [3];
    logic [PIX_W-1:0] r_s1_mid [3];
    logic [PIX_W-1:0] r_s1_hi [3];
    logic [PIX_W-1:0] r_s1_ctr;
    logic             r_s1_valid;
    logic             r_s1_border;
    logic             r_s1_last;

    logic [PIX_W-1:0] r_s2_maxlo;
    logic [PIX_W-1:0] r_s2_medmid;
    logic [PIX_W-1:0] r_s2_minhi;
    logic [PIX_W-1:0] r_s2_min;
    logic [PIX_W-1:0] r_s2_max;
    logic [PIX_W-1:0] r_s2_ctr;
    logic             r_s2_valid;
    logic             r_s2_border;
    logic             r_s2_last;

    logic             r_m_valid;
    logic [PIX_W-1:0] r_m_pixel;
    logic             r_m_last;

    logic                w_en;
    logic                w_in_hs;
    logic                w_flush_step;
    logic                w_step;
    logic                w_emit;
    logic                w_c_last;
    logic                w_border;
    logic                w_cfg_ok;
    logic [C_ADDR_W-1:0] w_addr;
    logic [PIX_W-1:0]    w_pix_in;
    logic [PIX_W-1:0]    w_lb_top;
    logic [PIX_W-1:0]    w_lb_mid;
    logic [PIX_W-1:0]    w_result;

    assign w_en         = !r_m_valid || m_ready_i;
    assign s_ready_o    = (r_state == S_RUN) && w_en;
    assign w_in_hs      = s_valid_i && s_ready_o;
    assign w_flush_step = (r_state == S_FLUSH) && w_en && !r_emit_done;
    assign w_step       = w_in_hs || w_flush_step;
    // A step at raster index j completes the window centred on j-W-1.
    assign w_emit       = w_step && (r_in_row != '0) &&
                          !((r_in_row == (DIM_W+1)'(1)) && (r_in_col == '0));
    assign w_c_last     = (r_c_col == r_w_m1) && (r_c_row == r_h_m1);
    assign w_border     = (r_c_row == '0) || (r_c_row == r_h_m1) ||
                          (r_c_col == '0) || (r_c_col == r_w_m1);
    assign w_cfg_ok     = (img_width_i >= DIM_W'(3)) && (img_height_i >= DIM_W'(3)) &&
                          ({1'b0, img_width_i} <= C_MAX_W);
    assign w_addr       = r_in_col[C_ADDR_W-1:0];
    assign w_pix_in     = (r_state == S_RUN) ? s_pixel_i : '0;
    assign w_lb_top     = r_lb_top[w_addr];
    assign w_lb_mid     = r_lb_mid[w_addr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'd0;
            r_w_m1      <= '0;
            r_h_m1      <= '0;
            r_in_col    <= '0;
            r_in_row    <= '0;
            r_c_col     <= '0;
            r_c_row     <= '0;
            r_emit_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_step) begin
                if (r_in_col == r_w_m1) begin
                    r_in_col <= '0;
                    r_in_row <= r_in_row + 1'b1;
                end else begin
                    r_in_col <= r_in_col + 1'b1;
                end
            end
            if (w_emit) begin
                if (w_c_last) begin
                    r_emit_done <= 1'b1;
                end
                if (r_c_col == r_w_m1) begin
                    r_c_col <= '0;
                    r_c_row <= r_c_row + 1'b1;
                end else begin
                    r_c_col <= r_c_col + 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (w_cfg_ok) begin
                            r_mode      <= mode_i;
                            r_w_m1      <= img_width_i - 1'b1;
                            r_h_m1      <= img_height_i - 1'b1;
                            r_in_col    <= '0;
                            r_in_row    <= '0;
                            r_c_col     <= '0;
                            r_c_row     <= '0;
                            r_emit_done <= 1'b0;
                            r_state     <= S_RUN;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_in_hs && (r_in_col == r_w_m1) && (r_in_row == {1'b0, r_h_m1})) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (r_m_valid && m_ready_i && r_m_last) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line buffers hold the two previous rows at the current column.
    always_ff @(posedge CLK) begin
        if (w_step) begin
            r_lb_mid[w_addr] <= w_pix_in;
            r_lb_top[w_addr] <= w_lb_mid;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_win_valid <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_pixel   <= '0;
            r_m_last    <= 1'b0;
        end else if (w_en) begin
            r_win_valid  <= w_emit;
            r_win_border <= w_border;
            r_win_last   <= w_c_last;
            if (w_step) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lb_top;
                r_win[1][2] <= w_lb_mid;
                r_win[2][2] <= w_pix_in;
            end

            for (int c = 0; c < 3; c++) begin
                r_s1_lo[c]  <= f_min3(r_win[0][c], r_win[1][c], r_win[2][c]);
                r_s1_mid[c] <= f_med3(r_win[0][c], r_win[1][c], r_win[2][c]);
                r_s1_hi[c]  <= f_max3(r_win[0][c], r_win[1][c], r_win[2][c]);
            end
            r_s1_ctr    <= r_win[1][1];
            r_s1_valid  <= r_win_valid;
            r_s1_border <= r_win_border;
            r_s1_last   <= r_win_last;

            r_s2_maxlo  <= f_max3(r_s1_lo[0], r_s1_lo[1], r_s1_lo[2]);
            r_s2_medmid <= f_med3(r_s1_mid[0], r_s1_mid[1], r_s1_mid[2]);
            r_s2_minhi  <= f_min3(r_s1_hi[0], r_s1_hi[1], r_s1_hi[2]);
            r_s2_min    <= f_min3(r_s1_lo[0], r_s1_lo[1], r_s1_lo[2]);
            r_s2_max    <= f_max3(r_s1_hi[0], r_s1_hi[1], r_s1_hi[2]);
            r_s2_ctr    <= r_s1_ctr;
            r_s2_valid  <= r_s1_valid;
            r_s2_border <= r_s1_border;
            r_s2_last   <= r_s1_last;

            r_m_valid <= r_s2_valid;
            r_m_last  <= r_s2_valid && r_s2_last;
            r_m_pixel <= w_result;
        end
    end

    always_comb begin
        w_result = r_s2_ctr;
        if (!r_s2_border) begin
            case (r_mode)
                2'd1:    w_result = f_med3(r_s2_maxlo, r_s2_medmid, r_s2_minhi);
                2'd2:    w_result = r_s2_min;
                2'd3:    w_result = r_s2_max;
                default: w_result = r_s2_ctr;
            endcase
        end
    end

    assign m_valid_o = r_m_valid;
    assign m_pixel_o = r_m_pixel;
    assign m_last_o  = r_m_last;
    assign busy_o    = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign done_o    = (r_state == S_DONE);
    assign err_o     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_median_filter_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_median_filter_stream                                                  |
// | Directed self-checking bench for the streaming 3x3 rank filter.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_median_filter_stream;

    localparam int PIX_W     = 8;
    localparam int MAX_WIDTH = 1024;
    localparam int DIM_W     = 11;

    logic             CLK;
    logic             RST;
    logic             start_i;
    logic [DIM_W-1:0] img_width_i;
    logic [DIM_W-1:0] img_height_i;
    logic [1:0]       mode_i;
    logic             s_valid_i;
    logic             s_ready_o;
    logic [PIX_W-1:0] s_pixel_i;
    logic             m_valid_o;
    logic             m_ready_i;
    logic [PIX_W-1:0] m_pixel_o;
    logic             m_last_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] img [0:63];
    logic [7:0] out_pix [0:127];
    logic       out_last [0:127];
    int         n_out, acc_cyc, first_v_cyc, last_hs_cyc, done_cyc, rdy_viol, hold_viol;
    bit         timed_out;

    median_filter_stream #(
        .PIX_W    (PIX_W),
        .MAX_WIDTH(MAX_WIDTH),
        .DIM_W    (DIM_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start_i     (start_i),
        .img_width_i (img_width_i),
        .img_height_i(img_height_i),
        .mode_i      (mode_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .s_pixel_i   (s_pixel_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_pixel_o   (m_pixel_o),
        .m_last_o    (m_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] model_pix(input int w, input int h, input int mode, input int k);
        int         r, c, n;
        logic [7:0] v [9];
        logic [7:0] t;
        r = k / w;
        c = k % w;
        if (mode == 0 || r == 0 || r == h - 1 || c == 0 || c == w - 1) return img[k];
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                v[n] = img[(r + dr) * w + (c + dc)];
                n++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
            end
        end
        case (mode)
            1:       return v[4];
            2:       return v[0];
            default: return v[8];
        endcase
    endfunction

    // Starts a frame, streams img[] in, collects outputs until done_o, and
    // records timing and stall-behaviour observations for the caller.
    task automatic run_frame(input int w, input int h, input logic [1:0] mode, input int rdiv);
        int         in_idx;
        int         cyc;
        bit         done_seen;
        bit         stalled;
        logic [7:0] held_pix;
        logic       held_last;
        in_idx = 0; cyc = 0; done_seen = 0; stalled = 0; held_pix = '0; held_last = 1'b0;
        n_out = 0; acc_cyc = -1; first_v_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        rdy_viol = 0; hold_viol = 0; timed_out = 0;
        img_width_i  = DIM_W'(w);
        img_height_i = DIM_W'(h);
        mode_i       = mode;
        start_i      = 1'b1;
        step();
        start_i = 1'b0;
        while (!done_seen && cyc < 3000) begin
            s_valid_i = (in_idx < w * h);
            s_pixel_i = (in_idx < w * h) ? img[in_idx] : 8'h00;
            m_ready_i = (rdiv <= 1) || (cyc % rdiv == rdiv - 1);
            #1;
            if (stalled && (!m_valid_o || m_pixel_o !== held_pix || m_last_o !== held_last)) hold_viol++;
            stalled = m_valid_o && !m_ready_i;
            if (stalled) begin
                held_pix  = m_pixel_o;
                held_last = m_last_o;
                if (s_ready_o) rdy_viol++;
            end
            if (m_valid_o && first_v_cyc < 0) first_v_cyc = cyc;
            if (s_valid_i && s_ready_o) begin
                if (in_idx == w + 1) acc_cyc = cyc;
                in_idx++;
            end
            if (m_valid_o && m_ready_i) begin
                if (n_out < 128) begin
                    out_pix[n_out]  = m_pixel_o;
                    out_last[n_out] = m_last_o;
                end
                n_out++;
                last_hs_cyc = cyc;
            end
            if (done_o) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            step();
            cyc++;
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b1;
        if (!done_seen) timed_out = 1;
    endtask

    task automatic test_reset();
        RST = 1'b1; start_i = 1'b0; s_valid_i = 1'b0; s_pixel_i = '0; m_ready_i = 1'b1;
        img_width_i = '0; img_height_i = '0; mode_i = 2'd0;
        repeat (3) step();
        RST = 1'b0;
        #1;
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b expected 0", m_valid_o); end
        n_checks++; if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got %b expected 0", s_ready_o); end
        n_checks++; if (m_pixel_o !== 8'h00) begin n_fail++; $display("FAIL reset_m_pixel got %h expected 00", m_pixel_o); end
        n_checks++; if ({m_last_o, busy_o, done_o, err_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got %b expected 0000", {m_last_o, busy_o, done_o, err_o});
        end
        step();
    endtask

    task automatic test_flat_frame();
        for (int i = 0; i < 20; i++) img[i] = 8'h40;
        run_frame(5, 4, 2'd1, 1);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL flat_timeout got timeout expected done"); end
        n_checks++; if (n_out !== 20) begin n_fail++; $display("FAIL flat_count got %0d expected 20", n_out); end
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (out_pix[i] !== 8'h40) begin n_fail++; $display("FAIL flat_pix[%0d] got %h expected 40", i, out_pix[i]); end
            n_checks++; if (out_last[i] !== (i == 19)) begin n_fail++; $display("FAIL flat_last[%0d] got %b expected %b", i, out_last[i], i == 19); end
        end
        n_checks++; if (done_cyc !== last_hs_cyc + 1) begin n_fail++; $display("FAIL flat_done_cycle got %0d expected %0d", done_cyc, last_hs_cyc + 1); end
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flat_busy_after got %b expected 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL flat_done_width got %b expected 0", done_o); end
        step();
    endtask

    task automatic test_rank_modes();
        int         r, c;
        bit         inner;
        logic [7:0] exp_v;
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 25; i++) img[i] = 8'h10;
            img[12] = (m == 2) ? 8'h00 : 8'hFF;
            run_frame(5, 5, (m == 0) ? 2'd1 : (m == 1) ? 2'd3 : 2'd2, 1);
            n_checks++; if (n_out !== 25) begin n_fail++; $display("FAIL rank%0d_count got %0d expected 25", m, n_out); end
            for (int k = 0; k < 25; k++) begin
                r = k / 5; c = k % 5;
                inner = (r >= 1 && r <= 3 && c >= 1 && c <= 3);
                if (m == 0)      exp_v = 8'h10;
                else if (m == 1) exp_v = inner ? 8'hFF : 8'h10;
                else             exp_v = inner ? 8'h00 : 8'h10;
                n_checks++; if (out_pix[k] !== exp_v) begin
                    n_fail++; $display("FAIL rank%0d_pix[%0d] got %h expected %h", m, k, out_pix[k], exp_v);
                end
            end
            step();
        end
    endtask

    task automatic test_bypass_latency();
        for (int i = 0; i < 24; i++) img[i] = 8'(i);
        run_frame(8, 3, 2'd0, 1);
        n_checks++; if (n_out !== 24) begin n_fail++; $display("FAIL ramp_count got %0d expected 24", n_out); end
        for (int i = 0; i < 24; i++) begin
            n_checks++; if (out_pix[i] !== 8'(i)) begin n_fail++; $display("FAIL ramp_pix[%0d] got %h expected %h", i, out_pix[i], 8'(i)); end
        end
        // m_valid_o first seen in cycle t means it rose on the edge closing cycle t-1.
        n_checks++; if (first_v_cyc - 1 - acc_cyc !== 3) begin
            n_fail++; $display("FAIL ramp_latency got %0d expected 3", first_v_cyc - 1 - acc_cyc);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_v;
        for (int i = 0; i < 36; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(6, 6, 2'd1, 3);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout got timeout expected done"); end
        n_checks++; if (n_out !== 36) begin n_fail++; $display("FAIL bp_count got %0d expected 36", n_out); end
        for (int k = 0; k < 36; k++) begin
            exp_v = model_pix(6, 6, 1, k);
            n_checks++; if (out_pix[k] !== exp_v) begin n_fail++; $display("FAIL bp_pix[%0d] got %h expected %h", k, out_pix[k], exp_v); end
        end
        n_checks++; if (rdy_viol !== 0) begin n_fail++; $display("FAIL bp_ready_in_stall got %0d expected 0", rdy_viol); end
        n_checks++; if (hold_viol !== 0) begin n_fail++; $display("FAIL bp_hold_in_stall got %0d expected 0", hold_viol); end
        n_checks++; if (out_last[35] !== 1'b1) begin n_fail++; $display("FAIL bp_last got %b expected 1", out_last[35]); end
        step();
    endtask

    task automatic test_bad_config();
        img_width_i = DIM_W'(2); img_height_i = DIM_W'(10); mode_i = 2'd1; start_i = 1'b1; s_valid_i = 1'b1;
        step();
        start_i = 1'b0;
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL cfg_err got %b expected 1", err_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL cfg_busy got %b expected 0", busy_o); end
        n_checks++; if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL cfg_ready got %b expected 0", s_ready_o); end
        step();
        s_valid_i = 1'b0;
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL cfg_err_width got %b expected 0", err_o); end
        img_width_i = DIM_W'(1025); img_height_i = DIM_W'(5); start_i = 1'b1;
        step();
        start_i = 1'b0;
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL cfg_err_wide got %b expected 1", err_o); end
        step();
        for (int i = 0; i < 9; i++) img[i] = 8'h55;
        run_frame(3, 3, 2'd1, 1);
        n_checks++; if (n_out !== 9) begin n_fail++; $display("FAIL cfg_after_count got %0d expected 9", n_out); end
        n_checks++; if (out_pix[4] !== 8'h55) begin n_fail++; $display("FAIL cfg_after_pix got %h expected 55", out_pix[4]); end
        step();
    endtask

    task automatic test_reset_abort();
        int cnt;
        int cyc;
        img_width_i = DIM_W'(6); img_height_i = DIM_W'(6); mode_i = 2'd1; start_i = 1'b1; m_ready_i = 1'b1;
        step();
        start_i = 1'b0;
        cnt = 0; cyc = 0;
        while (cnt < 10 && cyc < 100) begin
            s_valid_i = 1'b1;
            s_pixel_i = 8'($urandom_range(0, 255));
            #1;
            if (s_ready_o) cnt++;
            step();
            cyc++;
        end
        s_valid_i = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        n_checks++; if ({busy_o, m_valid_o} !== 2'b00) begin n_fail++; $display("FAIL abort_idle got %b expected 00", {busy_o, m_valid_o}); end
        step();
        for (int i = 0; i < 12; i++) img[i] = 8'h22;
        run_frame(4, 3, 2'd1, 1);
        n_checks++; if (n_out !== 12) begin n_fail++; $display("FAIL abort_count got %0d expected 12", n_out); end
        for (int i = 0; i < 12; i++) begin
            n_checks++; if (out_pix[i] !== 8'h22) begin n_fail++; $display("FAIL abort_pix[%0d] got %h expected 22", i, out_pix[i]); end
            n_checks++; if (out_last[i] !== (i == 11)) begin n_fail++; $display("FAIL abort_last[%0d] got %b expected %b", i, out_last[i], i == 11); end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_flat_frame();
        test_rank_modes();
        test_bypass_latency();
        test_backpressure();
        test_bad_config();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
